// File: rtl/mul_sequencer.sv
// Purpose: multi-cycle IEEE-754 single-precision multiplier (shift-add mantissa, RNE rounding).
// Latency: 27 edges from accepted start to done for normal operands, 1 edge for special operands.
// Backpressure: none; start is ignored while busy, the result is held until the next done.
//
// Ports:
//   clk, reset          - single clock, synchronous active-high reset
//   start, opa, opb     - request strobe and operands (sampled only when idle)
//   busy, done          - busy while not idle; done is a one-cycle pulse when result is valid
//   result              - packed single-precision product
//   invalid, overflow,
//   underflow, inexact  - exception flags, valid with done
module mul_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] opa,
   input  logic [31:0] opb,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic        invalid,
   output logic        overflow,
   output logic        underflow,
   output logic        inexact
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CHECK = 3'd1,
      MULT  = 3'd2,
      NORM  = 3'd3,
      ROUND = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t state, state_nxt;

   // operand capture and datapath registers
   logic [31:0]        opa_r, opb_r;
   logic               sign_r;
   logic [23:0]        manta, mantb;
   logic [24:0]        acc;
   logic [4:0]         cnt;
   logic signed [9:0]  expsum;
   logic [22:0]        mant;
   logic               guard, sticky;
   logic signed [9:0]  exp_r;

   // operand classification (valid while in CHECK)
   logic [7:0]  ea, eb;
   logic [22:0] fa, fb;
   logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   logic        sp_invalid, sp_inf, sp_zero, special;
   logic        sign_c;

   always_comb begin
      ea         = opa_r[30:23];
      eb         = opb_r[30:23];
      fa         = opa_r[22:0];
      fb         = opb_r[22:0];
      sign_c     = opa_r[31] ^ opb_r[31];
      // denormals have exp=0 and are flushed to zero here
      a_zero     = (ea == 8'h00);
      b_zero     = (eb == 8'h00);
      a_inf      = (ea == 8'hff) && (fa == 23'd0);
      b_inf      = (eb == 8'hff) && (fb == 23'd0);
      a_nan      = (ea == 8'hff) && (fa != 23'd0);
      b_nan      = (eb == 8'hff) && (fb != 23'd0);
      sp_invalid = a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf);
      sp_inf     = a_inf | b_inf;
      sp_zero    = a_zero | b_zero;
      special    = sp_invalid | sp_inf | sp_zero;
   end

   // one shift-add step: add multiplicand on multiplier lsb, then shift {acc, mantb} right
   logic [24:0] sum;
   logic [47:0] prod;

   always_comb begin
      sum  = acc + {1'b0, (mantb[0] ? manta : 24'd0)};
      prod = {acc[23:0], mantb};
   end

   // round to nearest-even; a carry out of the 24-bit significand bumps the exponent
   logic               round_up;
   logic [23:0]        mant_rnd;
   logic signed [9:0]  exp_rnd;
   logic               ovf_c, unf_c;

   always_comb begin
      round_up = guard & (sticky | mant[0]);
      mant_rnd = {1'b0, mant} + {23'd0, round_up};
      exp_rnd  = exp_r + (mant_rnd[23] ? 10'sd1 : 10'sd0);
      ovf_c    = (exp_rnd >= 10'sd255);
      unf_c    = (exp_rnd <= 10'sd0);
   end

   // state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = CHECK;
         CHECK:   state_nxt = special ? DONE : MULT;
         MULT:    if (cnt == 5'd23) state_nxt = NORM;
         NORM:    state_nxt = ROUND;
         ROUND:   state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   // datapath and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         opa_r     <= 32'd0;
         opb_r     <= 32'd0;
         sign_r    <= 1'b0;
         manta     <= 24'd0;
         mantb     <= 24'd0;
         acc       <= 25'd0;
         cnt       <= 5'd0;
         expsum    <= 10'sd0;
         mant      <= 23'd0;
         guard     <= 1'b0;
         sticky    <= 1'b0;
         exp_r     <= 10'sd0;
         result    <= 32'd0;
         invalid   <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         inexact   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  opa_r     <= opa;
                  opb_r     <= opb;
                  invalid   <= 1'b0;
                  overflow  <= 1'b0;
                  underflow <= 1'b0;
                  inexact   <= 1'b0;
               end
            end
            CHECK: begin
               sign_r <= sign_c;
               if (sp_invalid) begin
                  result  <= 32'h7fc0_0000;
                  invalid <= 1'b1;
               end else if (sp_inf) begin
                  result <= {sign_c, 8'hff, 23'd0};
               end else if (sp_zero) begin
                  result <= {sign_c, 31'd0};
               end else begin
                  manta  <= {1'b1, fa};
                  mantb  <= {1'b1, fb};
                  acc    <= 25'd0;
                  cnt    <= 5'd0;
                  expsum <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
               end
            end
            MULT: begin
               acc   <= {1'b0, sum[24:1]};
               mantb <= {sum[0], mantb[23:1]};
               cnt   <= cnt + 5'd1;
            end
            NORM: begin
               // product of two [1,2) significands lies in [1,4): bit 47 selects the scale
               if (prod[47]) begin
                  mant   <= prod[46:24];
                  guard  <= prod[23];
                  sticky <= |prod[22:0];
                  exp_r  <= expsum + 10'sd1;
               end else begin
                  mant   <= prod[45:23];
                  guard  <= prod[22];
                  sticky <= |prod[21:0];
                  exp_r  <= expsum;
               end
            end
            ROUND: begin
               if (ovf_c) begin
                  result   <= {sign_r, 8'hff, 23'd0};
                  overflow <= 1'b1;
                  inexact  <= 1'b1;
               end else if (unf_c) begin
                  result    <= {sign_r, 31'd0};
                  underflow <= 1'b1;
                  inexact   <= 1'b1;
               end else begin
                  result  <= {sign_r, exp_rnd[7:0], mant_rnd[22:0]};
                  inexact <= guard | sticky;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_sequencer.sv
module tb_mul_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [31:0] opa = 32'd0;
   logic [31:0] opb = 32'd0;
   logic        busy, done;
   logic [31:0] result;
   logic        invalid, overflow, underflow, inexact;

   mul_sequencer dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .opa       (opa),
      .opb       (opb),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .invalid   (invalid),
      .overflow  (overflow),
      .underflow (underflow),
      .inexact   (inexact)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [31:0] res;
      logic [3:0]  fl;    // {invalid, overflow, underflow, inexact}
      int          issue;
      int          lat;
      int          id;
   } exp_t;

   exp_t scb[$];
   int   next_id = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      tests++;
      if (act !== exp_v) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp_v, cyc);
      end
   endtask

   // Reference: exact integer product of the significands, then IEEE round-to-nearest-even
   function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic [3:0] fl, output int lat);
      logic s;
      int ea, eb, e, sh;
      logic [22:0] fa, fb;
      logic nan_a, nan_b, inf_a, inf_b, z_a, z_b;
      longint unsigned ma, mb, p, m, rem, half;
      s  = a[31] ^ b[31];
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      fa = a[22:0];
      fb = b[22:0];
      nan_a = (ea == 255) && (fa != 0);
      nan_b = (eb == 255) && (fb != 0);
      inf_a = (ea == 255) && (fa == 0);
      inf_b = (eb == 255) && (fb == 0);
      z_a   = (ea == 0);
      z_b   = (eb == 0);
      lat = 1;
      fl  = 4'b0000;
      if (nan_a || nan_b || (inf_a && z_b) || (z_a && inf_b)) begin
         r  = 32'h7fc00000;
         fl = 4'b1000;
      end else if (inf_a || inf_b) begin
         r = {s, 8'hff, 23'd0};
      end else if (z_a || z_b) begin
         r = {s, 31'd0};
      end else begin
         lat = 27;
         ma = (64'd1 << 23) | 64'(fa);
         mb = (64'd1 << 23) | 64'(fb);
         p  = ma * mb;
         e  = ea + eb - 127;
         sh = 23;
         if (p >= (64'd1 << 47)) begin
            sh = 24;
            e  = e + 1;
         end
         m    = p >> sh;
         rem  = p & ((64'd1 << sh) - 1);
         half = 64'd1 << (sh - 1);
         if (rem > half || (rem == half && m[0])) m = m + 1;
         if (m == (64'd1 << 24)) begin
            m = m >> 1;
            e = e + 1;
         end
         if (e >= 255) begin
            r  = {s, 8'hff, 23'd0};
            fl = 4'b0101;
         end else if (e <= 0) begin
            r  = {s, 31'd0};
            fl = 4'b0011;
         end else begin
            r  = {s, 8'(e), m[22:0]};
            fl = {3'b000, (rem != 0)};
         end
      end
   endfunction

   function automatic logic [31:0] rnd_op();
      logic       s;
      logic [7:0] e;
      logic [22:0] f;
      int k;
      k = int'($urandom_range(0, 19));
      s = 1'($urandom_range(0, 1));
      f = 23'($urandom);
      case (k)
         0:       e = 8'h00;
         1:       begin e = 8'hff; f = 23'd0; end
         2:       begin e = 8'hff; f = f | 23'd1; end
         3:       e = 8'($urandom_range(1, 254));
         4:       e = 8'($urandom_range(1, 12));
         5:       e = 8'($urandom_range(240, 254));
         6:       begin e = 8'($urandom_range(110, 144)); f = f & 23'h7ff000; end
         7:       begin e = 8'($urandom_range(110, 144)); f = 23'h7fffff; end
         default: e = 8'($urandom_range(90, 164));
      endcase
      return {s, e, f};
   endfunction

   // drive one request as soon as the DUT is idle; returns the cycle of the sampling edge
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                        input logic [3:0] fl, input int lat, output int t);
      int n;
      exp_t x;
      n = 0;
      t = -1;
      @(negedge clk);
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (busy) begin
         chk("issue_wait_timeout", 32'(busy), 32'd0);
      end else begin
         opa   = a;
         opb   = b;
         start = 1'b1;
         @(posedge clk);
         #1;
         t       = cyc;
         x.res   = r;
         x.fl    = fl;
         x.issue = t;
         x.lat   = lat;
         x.id    = next_id;
         next_id++;
         scb.push_back(x);
         chk("busy_rise", 32'(busy), 32'd1);
         @(negedge clk);
         start = 1'b0;
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy || scb.size() != 0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (busy || scb.size() != 0) chk("drain_timeout", 32'(scb.size()), 32'd0);
   endtask

   // monitor: every done pulse is matched against the oldest outstanding expectation
   bit prev_done = 1'b0;
   always @(negedge clk) begin
      exp_t x;
      if (done) begin
         if (prev_done) chk("done_width", 32'd2, 32'd1);
         if (scb.size() == 0) begin
            chk("unexpected_done", result, 32'hxxxxxxxx);
         end else begin
            x = scb.pop_front();
            chk($sformatf("result#%0d", x.id), result, x.res);
            chk($sformatf("flags#%0d", x.id), 32'({invalid, overflow, underflow, inexact}), 32'(x.fl));
            chk($sformatf("latency#%0d", x.id), 32'(cyc - x.issue), 32'(x.lat));
         end
      end
      prev_done = done;
   end

   initial begin
      logic [31:0] a, b, r;
      logic [3:0]  fl;
      int lat, t0, t1;

      // reset state, and reset winning over a simultaneous start
      repeat (3) @(posedge clk);
      @(negedge clk);
      start = 1'b1;
      opa   = 32'h3f800000;
      opb   = 32'h3f800000;
      @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_flags", 32'({invalid, overflow, underflow, inexact}), 32'd0);
      @(negedge clk);
      start = 1'b0;
      reset = 1'b0;

      // directed cases with hand-computed expectations
      issue(32'h3fc00000, 32'h40000000, 32'h40400000, 4'b0000, 27, t0);
      wait_idle();
      repeat (3) @(negedge clk);
      chk("result_hold", result, 32'h40400000);
      issue(32'h3f800001, 32'h3f800001, 32'h3f800002, 4'b0001, 27, t0);
      issue(32'h7f800000, 32'h00000000, 32'h7fc00000, 4'b1000, 1, t0);
      issue(32'hff800000, 32'h40000000, 32'hff800000, 4'b0000, 1, t0);
      issue(32'h7f000000, 32'h40000000, 32'h7f800000, 4'b0101, 27, t0);
      issue(32'h00800000, 32'h3f000000, 32'h00000000, 4'b0011, 27, t0);
      wait_idle();

      // start pulsed again at E5 must be ignored
      issue(32'h40000000, 32'h40400000, 32'h40c00000, 4'b0000, 27, t0);
      repeat (4) @(negedge clk);
      opa   = 32'h3f800000;
      opb   = 32'h7f800000;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      opa   = 32'd0;
      opb   = 32'd0;
      // back-to-back: next start accepted at E29
      issue(32'hc0000000, 32'h3f000000, 32'hbf800000, 4'b0000, 27, t1);
      chk("b2b_accept_edge", 32'(t1 - t0), 32'd29);
      wait_idle();

      // reset at E10 mid-MULT aborts with no partial result
      issue(32'h40400000, 32'h40400000, 32'h41100000, 4'b0000, 27, t0);
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      void'(scb.pop_back());
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_result", result, 32'd0);
      chk("midrst_flags", 32'({invalid, overflow, underflow, inexact}), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      issue(32'h3fc00000, 32'h3fc00000, 32'h40100000, 4'b0000, 27, t0);
      wait_idle();

      // randomized operands against the reference model
      for (int i = 0; i < 60; i++) begin
         a = rnd_op();
         b = rnd_op();
         model(a, b, r, fl, lat);
         issue(a, b, r, fl, lat, t0);
      end
      wait_idle();
      chk("scb_empty", 32'(scb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
